// File: rtl/test_pkg.sv
// Shared state encoding and frame geometry for the UART loopback.
// Build macro TEST_PARITY_EN adds an even-parity bit to every frame.
package test_pkg;

  localparam int DATA_BITS = 8;

`ifdef TEST_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef TEST_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

`ifdef TEST_PARITY_EN
  function automatic logic even_parity(input logic [DATA_BITS-1:0] value);
    return ^value;
  endfunction
`endif

endpackage

// File: rtl/test_if.sv
// Loopback link between the transmitter line and the receiver.
// The receiver returns its shift register and a one-cycle valid strobe.
interface test_if;
  import test_pkg::*;

  logic                 line;
  logic [DATA_BITS-1:0] data;
  logic                 valid;

  modport master (output line, input data, input valid);
  modport slave  (input line, output data, output valid);

endinterface

// File: rtl/test_uart_rx.sv
// UART receiver: falling-edge start detect, mid-bit sampling, stop check.
// Honors TEST_PARITY_EN by sampling and checking an even-parity bit.
module test_uart_rx
  import test_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input logic   clk,
  input logic   rst,
  test_if.slave link
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  // Strobe one cycle before the stop bit ends so the byte register lands on the frame boundary.
  localparam logic [CW-1:0] DONE = CW'(CLKS_PER_BIT - 2);

  state_t               state_reg, state_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [2:0]           idx_reg, idx_next;
  logic [DATA_BITS-1:0] data_reg, data_next;
  logic                 stop_reg, stop_next;
  logic                 line_reg;
  logic                 stop_ok;
  logic                 frame_ok;
  logic                 valid;
`ifdef TEST_PARITY_EN
  logic                 par_reg, par_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      data_reg  <= '0;
      stop_reg  <= 1'b0;
      line_reg  <= 1'b1;
`ifdef TEST_PARITY_EN
      par_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      data_reg  <= data_next;
      stop_reg  <= stop_next;
      line_reg  <= link.line;
`ifdef TEST_PARITY_EN
      par_reg   <= par_next;
`endif
    end
  end

  // With the shortest bit time the stop sample and the strobe share a cycle.
  assign stop_ok = (cnt_reg == MID) ? link.line : stop_reg;
`ifdef TEST_PARITY_EN
  assign frame_ok = stop_ok && (par_reg == even_parity(data_reg));
`else
  assign frame_ok = stop_ok;
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 1'b1;
    idx_next   = idx_reg;
    data_next  = data_reg;
    stop_next  = stop_reg;
    valid      = 1'b0;
`ifdef TEST_PARITY_EN
    par_next   = par_reg;
`endif
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (line_reg && !link.line) begin
          state_next = START;
          cnt_next   = CW'(1);
        end
      end
      START: begin
        if (cnt_reg == MID && link.line) begin
          state_next = IDLE;
        end else if (cnt_reg == LAST) begin
          state_next = DATA;
          cnt_next   = '0;
          idx_next   = '0;
        end
      end
      DATA: begin
        if (cnt_reg == MID) begin
          data_next = {link.line, data_reg[DATA_BITS-1:1]};
        end
        if (cnt_reg == LAST) begin
          cnt_next = '0;
          if (idx_reg == 3'd7) begin
`ifdef TEST_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end
      end
`ifdef TEST_PARITY_EN
      PARITY: begin
        if (cnt_reg == MID) begin
          par_next = link.line;
        end
        if (cnt_reg == LAST) begin
          cnt_next   = '0;
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_reg == MID) begin
          stop_next = link.line;
        end
        if (cnt_reg == DONE) begin
          state_next = IDLE;
          valid      = frame_ok;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign link.data  = data_reg;
  assign link.valid = valid;

endmodule

// File: rtl/test.sv
// UART loopback top: launch logic, transmitter FSM, received-byte register.
// Build macro TEST_PARITY_EN inserts an even-parity bit before the stop bit.
module test
  import test_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] a,
  output logic [DATA_BITS-1:0] b,
  output logic                 txd,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  state_t               state_reg, state_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [2:0]           idx_reg, idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [DATA_BITS-1:0] last_sent_reg, last_sent_next;
  logic [DATA_BITS-1:0] b_reg;
  logic                 txd_reg, txd_next;
  logic                 launch;
`ifdef TEST_PARITY_EN
  logic                 par_reg, par_next;
`endif

  test_if link ();

  test_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk  (clk),
    .rst  (rst),
    .link (link)
  );

  assign launch = (state_reg == IDLE) && (a != last_sent_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      shift_reg     <= '0;
      last_sent_reg <= '0;
      txd_reg       <= 1'b1;
      b_reg         <= '0;
`ifdef TEST_PARITY_EN
      par_reg       <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      shift_reg     <= shift_next;
      last_sent_reg <= last_sent_next;
      txd_reg       <= txd_next;
      if (link.valid) begin
        b_reg <= link.data;
      end
`ifdef TEST_PARITY_EN
      par_reg       <= par_next;
`endif
    end
  end

  // txd is registered, so each bit value is chosen on the last cycle of the previous bit.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg + 1'b1;
    idx_next       = idx_reg;
    shift_next     = shift_reg;
    last_sent_next = last_sent_reg;
    txd_next       = txd_reg;
`ifdef TEST_PARITY_EN
    par_next       = par_reg;
`endif
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        txd_next = 1'b1;
        if (launch) begin
          state_next     = START;
          shift_next     = a;
          last_sent_next = a;
          txd_next       = 1'b0;
`ifdef TEST_PARITY_EN
          par_next       = even_parity(a);
`endif
        end
      end
      START: begin
        if (cnt_reg == LAST) begin
          state_next = DATA;
          cnt_next   = '0;
          idx_next   = '0;
          txd_next   = shift_reg[0];
          shift_next = shift_reg >> 1;
        end
      end
      DATA: begin
        if (cnt_reg == LAST) begin
          cnt_next = '0;
          if (idx_reg == 3'd7) begin
`ifdef TEST_PARITY_EN
            state_next = PARITY;
            txd_next   = par_reg;
`else
            state_next = STOP;
            txd_next   = 1'b1;
`endif
          end else begin
            idx_next   = idx_reg + 3'd1;
            txd_next   = shift_reg[0];
            shift_next = shift_reg >> 1;
          end
        end
      end
`ifdef TEST_PARITY_EN
      PARITY: begin
        if (cnt_reg == LAST) begin
          state_next = STOP;
          cnt_next   = '0;
          txd_next   = 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt_reg == LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
          txd_next   = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        txd_next   = 1'b1;
      end
    endcase
  end

  assign link.line = txd_reg;
  assign txd       = txd_reg;
  assign b         = b_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_test.sv
// Self-checking bench for the UART loopback; frame timing comes from a
// bit-list model of the serial format, with randomized byte sequences.
`timescale 1ns/1ps
module tb_test;
  import test_pkg::*;

  localparam int N  = 16;
  localparam int FB = FRAME_BITS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a   = 8'h00;
  logic [7:0] b;
  logic       txd;
  logic       busy;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] last_m = 8'h00;
  logic [7:0] b_m    = 8'h00;

  test_if mon ();
  assign mon.line  = txd;
  assign mon.data  = b;
  assign mon.valid = busy;

  test #(.CLKS_PER_BIT(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .txd  (txd),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // Serial frame: start 0, data LSB first, optional even parity, stop 1.
  function automatic logic exp_bit(input logic [7:0] v, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return v[k-1];
    if (k == FB - 1) return 1'b1;
    return ^v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered in the launch cycle L with a == v; leaves in cycle L+FB*N+1.
  task automatic frame(input logic [7:0] v, input int chg_at, input logic [7:0] chg_val);
    logic [7:0] old_b;
    logic [7:0] exp_b;
    logic       exp_t;
    old_b = b_m;
    for (int j = 1; j <= FB * N; j++) begin
      step();
      if (j == chg_at) a = chg_val;
      exp_t = exp_bit(v, (j - 1) / N);
      exp_b = (j >= FB * N) ? v : old_b;
      n_cmp++;
      if (mon.line !== exp_t) begin
        n_err++;
        $display("FAIL frame_txd byte=%h L+%0d got %b want %b", v, j, mon.line, exp_t);
      end
      n_cmp++;
      if (busy !== 1'b1) begin
        n_err++;
        $display("FAIL frame_busy byte=%h L+%0d got %b want 1", v, j, busy);
      end
      n_cmp++;
      if (b !== exp_b) begin
        n_err++;
        $display("FAIL frame_b byte=%h L+%0d got %h want %h", v, j, b, exp_b);
      end
    end
    last_m = v;
    b_m    = v;
    step();
    n_cmp++;
    if (busy !== 1'b0 || txd !== 1'b1) begin
      n_err++;
      $display("FAIL frame_end byte=%h busy=%b txd=%b want busy=0 txd=1", v, busy, txd);
    end
    $display("frame %h done, b=%h", v, b);
  endtask

  task automatic do_reset();
    a   = 8'h00;
    rst = 1'b1;
    step();
    step();
    rst    = 1'b0;
    last_m = 8'h00;
    b_m    = 8'h00;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (b !== 8'h00 || txd !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state got b=%h txd=%b busy=%b want b=00 txd=1 busy=0", b, txd, busy);
    end
    $display("reset: b=%h txd=%b busy=%b", b, txd, busy);
  endtask

  task automatic test_idle_hold();
    int bad;
    bad = 0;
    a = 8'h00;
    for (int i = 0; i < 500; i++) begin
      step();
      n_cmp++;
      if (txd !== 1'b1 || busy !== 1'b0 || b !== 8'h00) begin
        n_err++;
        bad++;
        if (bad < 5) $display("FAIL idle_hold cycle %0d got txd=%b busy=%b b=%h want 1/0/00", i, txd, busy, b);
      end
    end
    $display("idle hold 500 cycles, errors=%0d", bad);
  endtask

  task automatic test_single();
    a = 8'hAD;
    frame(8'hAD, 0, 8'h00);
  endtask

  task automatic test_no_relaunch();
    int bad;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      n_cmp++;
      if (txd !== 1'b1 || busy !== 1'b0 || b !== b_m) begin
        n_err++;
        bad++;
        if (bad < 5) $display("FAIL no_relaunch cycle %0d got txd=%b busy=%b b=%h want 1/0/%h", i, txd, busy, b, b_m);
      end
    end
    $display("constant a=%h for 300 cycles, errors=%0d", a, bad);
  endtask

  task automatic test_back_to_back();
    do_reset();
    a = 8'hAD;
    frame(8'hAD, 10, 8'hBC);
    frame(8'hBC, 0, 8'h00);
  endtask

  task automatic test_mid_reset();
    do_reset();
    a = 8'hAD;
    for (int j = 1; j <= 80; j++) begin
      step();
      n_cmp++;
      if (txd !== exp_bit(8'hAD, (j - 1) / N)) begin
        n_err++;
        $display("FAIL mid_reset_txd L+%0d got %b want %b", j, txd, exp_bit(8'hAD, (j - 1) / N));
      end
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if (txd !== 1'b1 || busy !== 1'b0 || b !== 8'h00) begin
      n_err++;
      $display("FAIL mid_reset_abort got txd=%b busy=%b b=%h want 1/0/00", txd, busy, b);
    end
    $display("mid-frame reset: txd=%b busy=%b b=%h", txd, busy, b);
    last_m = 8'h00;
    b_m    = 8'h00;
    frame(8'hAD, 0, 8'h00);
  endtask

  task automatic test_parity_byte();
    do_reset();
    a = 8'hBC;
    frame(8'hBC, 0, 8'h00);
  endtask

  task automatic test_random();
    logic [7:0] v;
    logic [7:0] c;
    int         at;
    for (int it = 0; it < 8; it++) begin
      v = ($urandom_range(0, 3) == 0) ? last_m : 8'($urandom_range(0, 255));
      a = v;
      if (v == last_m) begin
        for (int i = 0; i < 20; i++) begin
          step();
          n_cmp++;
          if (busy !== 1'b0 || txd !== 1'b1) begin
            n_err++;
            $display("FAIL random_idle a=%h got busy=%b txd=%b want 0/1", v, busy, txd);
          end
        end
        $display("random: a=%h equals last sent, no launch", v);
      end else begin
        c  = 8'($urandom_range(0, 255));
        at = $urandom_range(1, FB * N - 1);
        frame(v, at, c);
        if (c != v) frame(c, 0, 8'h00);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_hold();
    test_single();
    test_no_relaunch();
    test_back_to_back();
    test_mid_reset();
    test_parity_byte();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
